// File: rtl/mr_ldst_pkg.sv
// Shared types for the mr_ldst Wishbone load-store initiator.
// The optional watchdog is enabled with `define MR_LDST_TIMEOUT_EN.
package mr_ldst_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_BUS      = 2'd1,
        CAUSE_MISALIGN = 2'd2,
        CAUSE_ABORT    = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_RETRY = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Watchdog width: enough bits for the limit, clamped to 8..16.
    function automatic int wdog_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        if (w < 8)  w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage

// File: rtl/mr_ldst_lane.sv
// Byte-lane steering for mr_ldst_wbm: selects, store replication,
// load extraction/extension and misalignment detect (purely combinational).
module mr_ldst_lane
    import mr_ldst_pkg::*;
(
    input  logic [1:0]      st_size,
    input  logic [1:0]      st_off,
    input  logic [XLEN-1:0] st_wdata,
    output logic [3:0]      st_sel,
    output logic [XLEN-1:0] st_data,
    output logic            st_misalign,
    input  logic [1:0]      ld_size,
    input  logic [1:0]      ld_off,
    input  logic            ld_unsigned,
    input  logic [XLEN-1:0] ld_data,
    output logic [XLEN-1:0] ld_ext
);

    logic [XLEN-1:0] ld_lane;

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        st_sel      = 4'hF;
        st_data     = st_wdata;
        st_misalign = 1'b0;
        case (size_e'(st_size))
            SZ_B: begin
                st_sel  = 4'b0001 << st_off;
                st_data = {4{st_wdata[7:0]}};
            end
            SZ_H: begin
                st_sel      = 4'b0011 << st_off;
                st_data     = {2{st_wdata[15:0]}};
                st_misalign = st_off[0];
            end
            default: st_misalign = |st_off;
        endcase
    end

    assign ld_lane = ld_data >> {ld_off, 3'b000};

    always_comb begin
        ld_ext = ld_lane;
        case (size_e'(ld_size))
            SZ_B: ld_ext = ld_unsigned ? {24'b0, ld_lane[7:0]}
                                       : {{24{ld_lane[7]}}, ld_lane[7:0]};
            SZ_H: ld_ext = ld_unsigned ? {16'b0, ld_lane[15:0]}
                                       : {{16{ld_lane[15]}}, ld_lane[15:0]};
            default: ld_ext = ld_lane;
        endcase
    end

endmodule

// File: rtl/mr_ldst_wbm.sv
// Wishbone B4 classic initiator for the load-store unit: one request at a time,
// retry/err handling, one registered response. Watchdog under MR_LDST_TIMEOUT_EN.
module mr_ldst_wbm
    import mr_ldst_pkg::*;
#(
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic [1:0]      rsp_cause,
    output logic [XLEN-1:0] wb_adr_o,
    output logic [XLEN-1:0] wb_dat_o,
    input  logic [XLEN-1:0] wb_dat_i,
    output logic            wb_we_o,
    output logic [3:0]      wb_sel_o,
    output logic            wb_stb_o,
    output logic            wb_cyc_o,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i
);

    localparam int RC_W = $clog2(MAX_RETRY + 2);

    state_e          state, state_next;
    cause_e          rsp_cause_next;
    logic            accept;
    logic            rsp_fire;
    logic            bus_start;
    logic            bus_stop;
    logic            retry_inc;
    logic            retry_exhausted;
    logic            timeout_hit;
    logic [RC_W-1:0] retry_cnt;
    logic [1:0]      r_size;
    logic [1:0]      r_off;
    logic            r_unsigned;

    logic [3:0]      st_sel;
    logic [XLEN-1:0] st_data;
    logic            st_misalign;
    logic [XLEN-1:0] ld_ext;

    mr_ldst_lane u_lane (
        .st_size     (req_size),
        .st_off      (req_addr[1:0]),
        .st_wdata    (req_wdata),
        .st_sel      (st_sel),
        .st_data     (st_data),
        .st_misalign (st_misalign),
        .ld_size     (r_size),
        .ld_off      (r_off),
        .ld_unsigned (r_unsigned),
        .ld_data     (wb_dat_i),
        .ld_ext      (ld_ext)
    );

    assign req_ready       = (state == ST_IDLE);
    assign accept          = req_valid && req_ready;
    // The current rty is re-issue number retry_cnt+1; beyond MAX_RETRY it fails.
    assign retry_exhausted = (int'(retry_cnt) >= MAX_RETRY);

`ifdef MR_LDST_TIMEOUT_EN
    localparam int WD_W = wdog_width(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wdog;

    // Counts BUS cycles; cleared outside BUS so each re-issue starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wdog <= '0;
        else if (state != ST_BUS)
            wdog <= '0;
        else
            wdog <= wdog + WD_W'(1);
    end

    assign timeout_hit = (int'(wdog) >= TIMEOUT_CYCLES - 1);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next     = state;
        rsp_fire       = 1'b0;
        rsp_cause_next = CAUSE_NONE;
        bus_start      = 1'b0;
        bus_stop       = 1'b0;
        retry_inc      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (st_misalign) begin
                        state_next     = ST_RESP;
                        rsp_fire       = 1'b1;
                        rsp_cause_next = CAUSE_MISALIGN;
                    end else begin
                        state_next = ST_BUS;
                        bus_start  = 1'b1;
                    end
                end
            end
            ST_BUS: begin
                if (wb_err_i) begin
                    state_next     = ST_RESP;
                    rsp_fire       = 1'b1;
                    rsp_cause_next = CAUSE_BUS;
                    bus_stop       = 1'b1;
                end else if (wb_ack_i) begin
                    state_next = ST_RESP;
                    rsp_fire   = 1'b1;
                    bus_stop   = 1'b1;
                end else if (wb_rty_i) begin
                    bus_stop = 1'b1;
                    if (retry_exhausted) begin
                        state_next     = ST_RESP;
                        rsp_fire       = 1'b1;
                        rsp_cause_next = CAUSE_ABORT;
                    end else begin
                        state_next = ST_RETRY;
                        retry_inc  = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_next     = ST_RESP;
                    rsp_fire       = 1'b1;
                    rsp_cause_next = CAUSE_ABORT;
                    bus_stop       = 1'b1;
                end
            end
            ST_RETRY: begin
                state_next = ST_BUS;
                bus_start  = 1'b1;
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the async reset clears every output register, so cyc/stb drop the instant rst rises.
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_cause  <= CAUSE_NONE;
            rsp_rdata  <= '0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_sel_o   <= 4'h0;
            wb_stb_o   <= 1'b0;
            wb_cyc_o   <= 1'b0;
            retry_cnt  <= '0;
            r_size     <= 2'd0;
            r_off      <= 2'd0;
            r_unsigned <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rsp_valid <= rsp_fire;
            rsp_err   <= rsp_fire && (rsp_cause_next != CAUSE_NONE);
            rsp_cause <= rsp_fire ? rsp_cause_next : CAUSE_NONE;
            // Only a successful load carries data; stores and failures return 0.
            rsp_rdata <= (rsp_fire && rsp_cause_next == CAUSE_NONE && !wb_we_o) ? ld_ext : '0;

            if (bus_start) begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
            end else if (bus_stop) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
            end

            if (accept) begin
                retry_cnt  <= '0;
                r_size     <= req_size;
                r_off      <= req_addr[1:0];
                r_unsigned <= req_unsigned;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + RC_W'(1);
            end

            // Bus-side fields stay frozen from accept through every re-issue.
            if (accept && !st_misalign) begin
                wb_adr_o <= {req_addr[XLEN-1:2], 2'b00};
                wb_dat_o <= st_data;
                wb_we_o  <= req_we;
                wb_sel_o <= st_sel;
            end
        end
    end

endmodule

// File: doc/mr_ldst_wbm.md
# mr_ldst_wbm

Wishbone B4 classic initiator for the load-store unit: accepts one memory request at a time from the `mr_ldst` pipeline stage and runs a single read or write cycle on the `wbm1_*` port of `wb_arbiter_2`. It generates byte selects and write-lane replication, and sign- or zero-extends load data. It handles `err`/`rty` terminations and misalignment, and returns one registered response per request.

## Interface
Parameters:
- `MAX_RETRY`, default 3: number of re-issues after `rty_i` before the request fails.
- `TIMEOUT_CYCLES`, default 255: watchdog limit, counted in cycles with `cyc_o` high. Used only with the timeout feature.

Ports (all 32-bit data widths are `XLEN`):
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: block can accept a request.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_size`, in, 2: 0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- `req_unsigned`, in, 1: zero-extend load data.
- `req_addr`, in, 32: byte address.
- `req_wdata`, in, 32: store data, right-aligned.
- `rsp_valid`, out, 1: one-cycle response pulse.
- `rsp_rdata`, out, 32: extended load data; 0 for stores and errors.
- `rsp_err`, out, 1: request failed.
- `rsp_cause`, out, 2: 0 = none, 1 = bus error, 2 = misaligned, 3 = retry exhausted or timeout.
- `wb_adr_o`, out, 32: word-aligned address (`req_addr` with bits [1:0] forced to 0).
- `wb_dat_o`, out, 32: write data.
- `wb_dat_i`, in, 32: read data.
- `wb_we_o`, out, 1: write enable.
- `wb_sel_o`, out, 4: byte selects.
- `wb_stb_o`, out, 1: strobe.
- `wb_cyc_o`, out, 1: cycle.
- `wb_ack_i`, in, 1: acknowledge.
- `wb_err_i`, in, 1: error termination.
- `wb_rty_i`, in, 1: retry termination.

## Operation
- FSM states and transitions:
  - `IDLE` to `BUS` on request accept.
  - `BUS` to `RETRY` on `rty_i`.
  - `RETRY` to `BUS` after one idle cycle.
  - `BUS` to `RESP` on any termination.
  - `IDLE` to `RESP` directly when the request is misaligned.
  - `RESP` to `IDLE` after one cycle.
- `req_ready` = (state == `IDLE`). A request is accepted on `req_valid && req_ready`; all request fields are registered at accept.
- Misalignment:
  - half with `addr[0] = 1`, or word with `addr[1:0] != 0`, is misaligned.
  - A misaligned request issues no bus cycle and responds with `rsp_err = 1`, `rsp_cause = 2`.
- Byte selects, with `off = addr[1:0]`:
  - byte: `sel = 4'b0001 << off`.
  - half: `sel = 4'b0011 << off`.
  - word: `sel = 4'hF`.
- Store lanes: byte data replicated as `{4{wdata[7:0]}}`; half as `{2{wdata[15:0]}}`; word unchanged.
- Load data: the lane selected by `off` is shifted down, then sign-extended from bit 7 or 15 unless `req_unsigned` is set.
- Termination priority within one cycle: `err_i` > `ack_i` > `rty_i`.
  - `err_i`: response with cause 1.
  - `ack_i`: response with cause 0; load data captured from `wb_dat_i` in the ack cycle.
  - `rty_i`: retry counter increments. When the counter exceeds `MAX_RETRY`, respond with cause 3 and do not re-issue.
- `wb_adr_o`, `wb_sel_o`, `wb_we_o` and `wb_dat_o` are held stable for the whole `BUS` state, including re-issues.
- Reset mid-operation: `cyc_o`/`stb_o` drop immediately; the in-flight request is discarded with no response.

## Timing
- Reset values:
  - `req_ready = 1`.
  - All `wb_*` outputs are 0.
  - `rsp_valid = rsp_err = 0`, `rsp_cause = 0`, `rsp_rdata = 0`.
- All outputs are registered except `req_ready`, which is decoded from state.
- `cyc_o` and `stb_o` rise in the cycle after accept and fall in the cycle after a sampled termination.
- `rsp_valid` is high exactly one cycle: the cycle after termination, or the cycle after accept for a misaligned request.
- Zero-wait slave: accept at edge 0, ack at edge 1, `rsp_valid` in the cycle after edge 1. Minimum latency is 2 cycles from accept to response.
- The response has no backpressure.
- The next accept is possible in the cycle after `rsp_valid`.
- Each retry costs one cycle with `cyc_o` low before re-assertion.

## Configuration
- `MR_LDST_TIMEOUT_EN` defined:
  - An 8..16-bit watchdog (sized from `TIMEOUT_CYCLES`) counts cycles with `cyc_o` high without termination.
  - The watchdog resets at each re-issue.
  - When it reaches `TIMEOUT_CYCLES`, the cycle is abandoned (`cyc_o` drops) and the response is `rsp_err = 1`, cause 3.
- `MR_LDST_TIMEOUT_EN` undefined: no watchdog logic, and the block waits indefinitely for a termination.

## Structure
- Package `mr_ldst_pkg` holds:
  - the size enum `SZ_B`/`SZ_H`/`SZ_W`;
  - the cause enum `CAUSE_NONE`/`CAUSE_BUS`/`CAUSE_MISALIGN`/`CAUSE_ABORT`;
  - the FSM state enum.
- Sub-module `mr_ldst_lane` (combinational) contains the select generation, store replication, load extraction/extension, and misalignment detect. The FSM, counters and registers stay in `mr_ldst_wbm`.

## Test plan
- Word load at `0x100`; slave returns `0xDEADBEEF` with ack in the first cycle. Expect `sel = F`, `adr = 0x100`, `rsp_rdata = 0xDEADBEEF`, `rsp_valid` 2 cycles after accept.
- Signed byte load at `0x103`, `dat_i = 0x80FF_FF00`. Expect `sel = 8`, `rsp_rdata = 0xFFFFFF80`. The same access with `req_unsigned = 1` gives `0x00000080`.
- Half store `0x1234` at `0x102`. Expect `sel = C`, `dat_o = 0x12341234`, `we_o = 1`, `rsp_err = 0`.
- Word load at `0x101`. Expect no `cyc_o` assertion, and a response 1 cycle after accept with `err = 1`, cause 2.
- Slave asserts `rty_i` 4 times with `MAX_RETRY = 3`. Expect 4 bus cycles, each separated by one cycle with `cyc_o` low, then cause 3. A test where `ack_i` and `err_i` are asserted together expects cause 1.
- Assert `rst` while `cyc_o` is high. Expect `cyc_o` and `stb_o` low asynchronously, no `rsp_valid`, and `req_ready = 1` after reset. With `MR_LDST_TIMEOUT_EN` defined and a silent slave, expect abort after `TIMEOUT_CYCLES` cycles with cause 3.
